// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
//   Serial bit-stream source for the consecutive-bit detector. Parallel words
//   are accepted over a valid/ready handshake and shifted out MSB-first on w,
//   one bit per clock. expected_z is a cycle-accurate model of the detector's
//   z output (z=1 in the cycle after two equal consecutive w values).
//
//   Optional feature: define PARITY_EN to append one even-parity bit
//   (XOR of the accepted word) after the WIDTH payload bits.
//
// Ports
//   clk         rising-edge clock
//   Reset       synchronous active-high reset
//   data_in     word to transmit, sampled on accept
//   load_valid  data_in valid
//   load_ready  transmitter can accept a word this cycle
//   w           serial bit to the detector (registered)
//   w_valid     w carries a payload (or parity) bit this cycle
//   busy        word in flight (FSM not in IDLE)
//   done        one-cycle pulse after the final bit slot of a word
//   expected_z  predicted detector z, aligned to the detector's z
//
// Handshake: a word is accepted at a rising edge where load_valid and
// load_ready are both 1. load_valid is ignored while load_ready is 0, and
// data_in is not looked at again after the accept.

module serial_pattern_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done,
    output logic             expected_z
);

    // One-hot state vector; the PARITY bit only exists with the feature on.
`ifdef PARITY_EN
    localparam int NS       = 3;
    localparam int S_PARITY = 2;
`else
    localparam int NS       = 2;
`endif
    localparam int S_IDLE  = 0;
    localparam int S_SHIFT = 1;
    localparam int CW      = $clog2(WIDTH);

    logic [NS-1:0]    state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic accept;
    logic last_bit;
    logic w_d, w_valid_d, done_d;

    // Detector model state
    logic seen_q;
    logic prev_q;

    // ------------------------------------------------------------------
    // State register (also holds the registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= NS'(1) << S_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
`ifdef PARITY_EN
            parity_q   <= 1'b0;
`endif
            w          <= IDLE_LEVEL;
            w_valid    <= 1'b0;
            done       <= 1'b0;
            seen_q     <= 1'b0;
            prev_q     <= 1'b0;
            expected_z <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
`ifdef PARITY_EN
            parity_q   <= parity_d;
`endif
            w          <= w_d;
            w_valid    <= w_valid_d;
            done       <= done_d;
            // The detector samples w every clock; z follows one cycle after
            // the second of two equal samples.
            seen_q     <= 1'b1;
            prev_q     <= w;
            expected_z <= seen_q && (w == prev_q);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = '0;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef PARITY_EN
        parity_d = accept ? ^data_in : parity_q;
`endif
        if (accept) begin
            // Also covers a back-to-back accept during the last-bit slot.
            state_d[S_SHIFT] = 1'b1;
            shreg_d          = data_in;
            cnt_d            = CW'(WIDTH - 1);
        end else if (state_q[S_SHIFT]) begin
            if (cnt_q != '0) begin
                state_d[S_SHIFT] = 1'b1;
                shreg_d          = shreg_q << 1;
                cnt_d            = cnt_q - 1'b1;
            end else begin
`ifdef PARITY_EN
                state_d[S_PARITY] = 1'b1;
`else
                state_d[S_IDLE]   = 1'b1;
`endif
            end
        end else begin
            // IDLE with no accept, or PARITY with no follow-on word.
            state_d[S_IDLE] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        last_bit = state_q[S_SHIFT] && (cnt_q == '0);
`ifdef PARITY_EN
        load_ready = state_q[S_IDLE] || state_q[S_PARITY];
        done_d     = state_q[S_PARITY];
`else
        load_ready = state_q[S_IDLE] || last_bit;
        done_d     = last_bit;
`endif
        accept    = load_valid && load_ready;
        busy      = !state_q[S_IDLE];
        w_valid_d = !state_d[S_IDLE];
        // w is loaded with the bit that belongs to the upcoming cycle.
        if (state_d[S_SHIFT]) begin
            w_d = shreg_d[WIDTH-1];
`ifdef PARITY_EN
        end else if (state_d[S_PARITY]) begin
            w_d = parity_d;
`endif
        end else begin
            w_d = IDLE_LEVEL;
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx
//   Table-driven bench for serial_pattern_tx (WIDTH=8, IDLE_LEVEL=0).
//   Each record holds the inputs applied before a rising edge and the
//   outputs expected just after that edge. Without PARITY_EN the table
//   covers reset/idle, a single word, back-to-back words, reset mid-word and
//   load_valid pulses while busy; with PARITY_EN it covers reset/idle and a
//   parity frame. A hand-written sequence then collects one full frame.

module tb_serial_pattern_tx;

    logic       clk;
    logic       Reset;
    logic [7:0] data_in;
    logic       load_valid;
    logic       load_ready;
    logic       w;
    logic       w_valid;
    logic       busy;
    logic       done;
    logic       expected_z;

    int n_vec;
    int n_err;

    serial_pattern_tx #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .w          (w),
        .w_valid    (w_valid),
        .busy       (busy),
        .done       (done),
        .expected_z (expected_z)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       lv;
        logic [7:0] din;
        logic       w;
        logic       wv;
        logic       busy;
        logic       done;
        logic       rdy;
        logic       ez;
        logic       ez_chk;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic lv, input logic [7:0] din,
                                input logic ew, input logic ewv, input logic ebusy,
                                input logic edone, input logic erdy, input logic eez,
                                input logic ezc);
        vec_t v;
        v.rst = rst; v.lv = lv; v.din = din;
        v.w = ew; v.wv = ewv; v.busy = ebusy; v.done = edone;
        v.rdy = erdy; v.ez = eez; v.ez_chk = ezc;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic act, input logic exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    task automatic build_table();
        // Reset, then idle: z model needs two equal samples after reset.
        repeat (3) add(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0);
        repeat (3) add(0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 1);
`ifdef PARITY_EN
        // 8'h07 -> 0,0,0,0,0,1,1,1 then parity 1
        add(0, 1, 8'h07, 0, 1, 1, 0, 0, 1, 1);
        repeat (4) add(0, 0, 8'h00, 0, 1, 1, 0, 0, 1, 1);
        add(0, 0, 8'h00, 1, 1, 1, 0, 0, 1, 1);
        add(0, 0, 8'h00, 1, 1, 1, 0, 0, 0, 1);
        add(0, 0, 8'h00, 1, 1, 1, 0, 0, 1, 1);
        add(0, 0, 8'h00, 1, 1, 1, 0, 1, 1, 1);   // parity slot, ready
        add(0, 0, 8'h00, 0, 0, 0, 1, 1, 1, 1);   // done
        add(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 1);
`else
        // 8'hA5 -> 1,0,1,0,0,1,0,1
        add(0, 1, 8'hA5, 1, 1, 1, 0, 0, 1, 1);
        add(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 1);
        add(0, 0, 8'h00, 1, 1, 1, 0, 0, 0, 1);
        add(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 1);
        add(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 1);
        add(0, 0, 8'h00, 1, 1, 1, 0, 0, 1, 1);   // after the 0,0 pair
        add(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 1);
        add(0, 0, 8'h00, 1, 1, 1, 0, 1, 0, 1);   // last bit, ready
        add(0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 1);   // done
        add(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 1);
        // Back-to-back 8'hFF then 8'h00 with load_valid held
        add(0, 1, 8'hFF, 1, 1, 1, 0, 0, 1, 1);
        add(0, 1, 8'hFF, 1, 1, 1, 0, 0, 0, 1);
        repeat (5) add(0, 1, 8'hFF, 1, 1, 1, 0, 0, 1, 1);
        add(0, 1, 8'hFF, 1, 1, 1, 0, 1, 1, 1);
        add(0, 1, 8'h00, 0, 1, 1, 1, 0, 1, 1);   // second word, first done
        add(0, 1, 8'h00, 0, 1, 1, 0, 0, 0, 1);
        repeat (5) add(0, 1, 8'h00, 0, 1, 1, 0, 0, 1, 1);
        add(0, 1, 8'h00, 0, 1, 1, 0, 1, 1, 1);
        add(0, 0, 8'h00, 0, 0, 0, 1, 1, 1, 1);   // second done
        add(0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 1);
        // 8'h3C with Reset on the 4th bit
        add(0, 1, 8'h3C, 0, 1, 1, 0, 0, 1, 1);
        add(0, 0, 8'h00, 0, 1, 1, 0, 0, 1, 1);
        add(0, 0, 8'h00, 1, 1, 1, 0, 0, 1, 1);
        add(0, 0, 8'h00, 1, 1, 1, 0, 0, 0, 1);
        add(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 1);
        // 8'h96 -> 1,0,0,1,0,1,1,0 with load_valid pulses mid-word
        add(0, 1, 8'h96, 1, 1, 1, 0, 0, 1, 1);
        add(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 1);
        add(0, 1, 8'hFF, 0, 1, 1, 0, 0, 0, 1);
        add(0, 0, 8'h00, 1, 1, 1, 0, 0, 1, 1);
        add(0, 1, 8'h00, 0, 1, 1, 0, 0, 0, 1);
        add(0, 0, 8'h00, 1, 1, 1, 0, 0, 0, 1);
        add(0, 0, 8'h00, 1, 1, 1, 0, 0, 0, 1);
        add(0, 0, 8'h00, 0, 1, 1, 0, 1, 1, 1);
        add(0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 1);
        add(0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 1);
`endif
    endtask

    // Drive one word from idle and collect the frame off w until done.
    task automatic frame_sequence();
        logic [8:0] got;
        logic [8:0] exp_frame;
        int         nbits;
        int         exp_bits;
        int         ndone;
        bit         finished;
`ifdef PARITY_EN
        exp_frame = {8'h81, 1'b0};
        exp_bits  = 9;
`else
        exp_frame = {1'b0, 8'h81};
        exp_bits  = 8;
`endif
        got = '0; nbits = 0; ndone = 0; finished = 1'b0;
        n_vec++;
        load_valid = 1'b1;
        data_in    = 8'h81;
        @(posedge clk); #1;
        load_valid = 1'b0;
        data_in    = 8'h5A;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (w_valid) begin
                got = {got[7:0], w};
                nbits++;
            end
            if (done) begin
                ndone++;
                finished = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!finished) begin
            n_err++;
            $display("FAIL frame_timeout: got no done within 20 cycles, expected done");
        end
        if (nbits != exp_bits) begin
            n_err++;
            $display("FAIL frame_len: got %0d bits expected %0d", nbits, exp_bits);
        end
        if (got !== exp_frame) begin
            n_err++;
            $display("FAIL frame_bits: got %h expected %h", got, exp_frame);
        end
        @(posedge clk); #1;
        chk("frame_done_once", n_vec, done, 1'b0);
        chk("frame_idle_ready", n_vec, load_ready, 1'b1);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        Reset      = 1'b1;
        load_valid = 1'b0;
        data_in    = 8'h00;
        build_table();
        foreach (vecs[i]) begin
            Reset      = vecs[i].rst;
            load_valid = vecs[i].lv;
            data_in    = vecs[i].din;
            @(posedge clk); #1;
            n_vec++;
            chk("w",          i, w,          vecs[i].w);
            chk("w_valid",    i, w_valid,    vecs[i].wv);
            chk("busy",       i, busy,       vecs[i].busy);
            chk("done",       i, done,       vecs[i].done);
            chk("load_ready", i, load_ready, vecs[i].rdy);
            if (vecs[i].ez_chk)
                chk("expected_z", i, expected_z, vecs[i].ez);
        end
        load_valid = 1'b0;
        Reset      = 1'b0;
        frame_sequence();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
Serial bit-stream transmitter that drives the single-bit `w` input of the one-hot consecutive-bit detector (z=1 after two equal consecutive bits). It accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock. It also produces `expected_z`, a cycle-accurate model of the detector's `z`, so the pair can be self-checked in system.

Parameters:
WIDTH, 8, bits per word; legal range 2..32
IDLE_LEVEL, 0, value driven on w when no word is being sent

Ports:
clk  input  1  rising-edge clock
Reset  input  1  synchronous active-high reset
data_in  input  WIDTH  word to transmit, sampled on accept
load_valid  input  1  data_in valid
load_ready  output  1  transmitter can accept a word this cycle
w  output  1  serial bit to the detector; registered
w_valid  output  1  w carries a payload (or parity) bit this cycle
busy  output  1  word in flight
done  output  1  one-cycle pulse after the final bit of a word
expected_z  output  1  predicted detector z, aligned to the detector's z

Behaviour:
- Reset is synchronous and active-high on clk; the clock port is `clk` and the reset port is `Reset`.
- Reset values: w=IDLE_LEVEL, w_valid=0, busy=0, done=0, expected_z=0, load_ready=1 (IDLE).
- FSM is one-hot, with states IDLE, SHIFT and PARITY (PARITY exists only with the optional feature). Exactly one state bit is set at all times.
- Accept means load_valid && load_ready at a rising edge. data_in is copied into the shift register, the bit counter is set to WIDTH-1, and the FSM enters SHIFT.
- SHIFT: starting in the cycle after accept, w = shreg[WIDTH-1] and w_valid=1. Each cycle the register shifts left by one and the counter decrements, so bits go out MSB-first for exactly WIDTH cycles.
- load_ready = IDLE, or SHIFT with counter==0 when the last-bit slot is not followed by a parity slot.
- Back-to-back: a word accepted during the last-bit cycle starts in the next cycle with no gap bit. In that case done still pulses and busy stays 1.
- After the last bit with no new accept: FSM goes to IDLE, w=IDLE_LEVEL, w_valid=0, busy=0.
- done=1 for exactly one cycle, in the cycle immediately after the final bit slot of each word.
- busy=1 whenever the FSM is not in IDLE.
- load_valid is ignored while load_ready=0. data_in changes after accept have no effect.
- expected_z models the detector, which samples w on every clock, idle cycles included. Let b_k be the value of w in the k-th cycle after Reset deasserts.
- expected_z is registered: it becomes 1 in the cycle after b_k iff k>=1 and b_k==b_{k-1}, otherwise 0. This requires a 1-bit previous-w register and a "seen one bit" flag, both cleared by Reset.
- Reset mid-word: the word is discarded and all outputs return to reset values on that edge. done does not pulse.

Optional Feature:
Macro PARITY_EN.
- Defined: after the WIDTH payload bits, one PARITY cycle drives w = even parity (XOR of the accepted word) with w_valid=1.
  - load_ready is 1 in the PARITY cycle, not in the last payload cycle.
  - done pulses in the cycle after the parity bit.
  - expected_z counts the parity bit like any other w value.
- Undefined: the PARITY state, its logic and its ready/done terms are absent. Frame length is WIDTH.

Test Plan:
1. Reset 3 cycles, then idle 4 cycles with IDLE_LEVEL=0 -> w=0, w_valid=0, load_ready=1. expected_z=0 in the first cycle after Reset, then 1 from the second idle cycle onward.
2. WIDTH=8, accept 8'hA5 while IDLE -> next 8 cycles w=1,0,1,0,0,1,0,1 with w_valid=1 and busy=1. done=1 exactly one cycle later. expected_z tracks the detector: 1 only after the 0,0 pair.
3. Hold load_valid=1 with 8'hFF then 8'h00 -> 16 contiguous bits with no gap and w_valid=1 throughout. The second accept happens in the last-bit cycle of the first word. done pulses twice, 8 cycles apart.
4. Assert Reset on the 4th bit of 8'h3C -> next cycle w=IDLE_LEVEL, busy=0, done=0, expected_z=0, load_ready=1. The word is not resumed.
5. load_valid pulsed while busy (mid-word) -> ignored. The in-flight word completes unchanged and exactly one done pulse occurs.
6. PARITY_EN defined, accept 8'h07 -> 8 payload bits then w=1 (parity) with w_valid=1. done pulses after the 9th bit. load_ready is high only during the parity cycle.
